dbg_uart_tx: RTL and testbench

Serial transmit back end for the debug byte stream. Accepts bytes on a valid/ready handshake from the debug core's TX byte port, buffers them in a small synchronous FIFO, and shifts each byte out on `txd` as an 8N1 UART frame. It sits between the debug core and the chip-level TX pin and absorbs bursts of console output while the core keeps servicing the management bus.

---
 rtl/dbg_uart_tx_pkg.sv | 20 ++
 rtl/dbg_uart_fifo.sv | 63 ++++++
 rtl/dbg_uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_dbg_uart_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// dbg_uart_tx_pkg
// Shared constants for the debug UART transmit path: FSM state encodings
// (3 bits) and the default bit-time divider / buffer depth.
// ---------------------------------------------------------------------------
package dbg_uart_tx_pkg;

    typedef enum logic [2:0] {
        UART_ST_IDLE  = 3'd0,
        UART_ST_START = 3'd1,
        UART_ST_DATA  = 3'd2,
        UART_ST_PAR   = 3'd3,
        UART_ST_STOP  = 3'd4
    } uart_state_e;

    // Clock cycles per UART bit (e.g. 100 MHz / 115200 baud).
    localparam int UART_DIV_DEFAULT        = 868;
    localparam int UART_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/dbg_uart_fifo.sv
// ---------------------------------------------------------------------------
// dbg_uart_fifo
// Synchronous byte FIFO with full/empty flags and a head-of-queue read port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (flushes pointers)
//   i_push    - write i_din (ignored while full)
//   i_din     - write data
//   i_pop     - advance the read pointer (ignored while empty)
//   o_head    - entry at the read pointer, valid while !o_empty
//   o_full    - all DEPTH entries occupied
//   o_empty   - no entries occupied
// ---------------------------------------------------------------------------
module dbg_uart_fifo
    import dbg_uart_tx_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH_DEFAULT,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_push;
    logic              w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Same index, opposite wrap bit: writer is a full lap ahead.
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/dbg_uart_tx.sv
// ---------------------------------------------------------------------------
// dbg_uart_tx
// Serial transmit back end for the debug byte stream. Bytes arrive on a
// valid/ready handshake, are buffered in dbg_uart_fifo and shifted out LSB
// first as 8N1 frames (8E1 when DBG_UART_PARITY_EN is defined). Frames are
// sent back to back with no idle gap while the buffer holds data.
//
// Build option:
//   DBG_UART_PARITY_EN - insert an even-parity bit after data bit 7.
//
// Ports:
//   clk, rst - clock, asynchronous active-high reset (aborts frame, flushes)
//   in_vld   - upstream byte valid
//   in_dat   - upstream byte, sampled on in_vld && in_rdy
//   in_rdy   - buffer not full
//   txd      - UART serial output, registered, idles high
//   busy     - frame in progress or buffer non-empty
// ---------------------------------------------------------------------------
module dbg_uart_tx
    import dbg_uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = UART_DIV_DEFAULT,
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_vld,
    input  logic [7:0] in_dat,
    output logic       in_rdy,
    output logic       txd,
    output logic       busy
);

    localparam int            BW        = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);

    uart_state_e r_state, w_state_nx;
    logic [BW-1:0] r_baud, w_baud_nx;
    logic [2:0]    r_bitcnt, w_bitcnt_nx;
    logic          r_txd, w_txd_nx;
    logic [7:0]    r_shreg, w_shreg_nx;
    logic          w_pop;
    logic          w_bit_end;
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
`ifdef DBG_UART_PARITY_EN
    logic          r_par, w_par_nx;
`endif

    dbg_uart_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_vld),
        .i_din   (in_dat),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign in_rdy    = !w_full;
    assign txd       = r_txd;
    assign busy      = (r_state != UART_ST_IDLE) || !w_empty;
    assign w_bit_end = (r_baud == '0);

    // Next-state / datapath decode. Every bit entry reloads the baud counter,
    // so each bit (start and stop included) lasts exactly CLK_DIV cycles.
    always_comb begin
        w_state_nx  = r_state;
        w_txd_nx    = r_txd;
        w_bitcnt_nx = r_bitcnt;
        w_shreg_nx  = r_shreg;
        w_pop       = 1'b0;
        w_baud_nx   = r_baud;
`ifdef DBG_UART_PARITY_EN
        w_par_nx    = r_par;
`endif
        if (r_state != UART_ST_IDLE && !w_bit_end) begin
            w_baud_nx = r_baud - BW'(1);
        end

        case (r_state)
            UART_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shreg_nx = w_head;
`ifdef DBG_UART_PARITY_EN
                    w_par_nx   = ^w_head;
`endif
                    w_txd_nx   = 1'b0;
                    w_baud_nx  = BAUD_LOAD;
                    w_state_nx = UART_ST_START;
                end
            end
            UART_ST_START: begin
                if (w_bit_end) begin
                    w_txd_nx    = r_shreg[0];
                    w_bitcnt_nx = 3'd0;
                    w_baud_nx   = BAUD_LOAD;
                    w_state_nx  = UART_ST_DATA;
                end
            end
            UART_ST_DATA: begin
                if (w_bit_end) begin
                    w_baud_nx = BAUD_LOAD;
                    if (r_bitcnt != 3'd7) begin
                        // Shifter bit 1 becomes the next bit on the wire.
                        w_shreg_nx  = {1'b0, r_shreg[7:1]};
                        w_txd_nx    = r_shreg[1];
                        w_bitcnt_nx = r_bitcnt + 3'd1;
                    end else begin
`ifdef DBG_UART_PARITY_EN
                        w_txd_nx   = r_par;
                        w_state_nx = UART_ST_PAR;
`else
                        w_txd_nx   = 1'b1;
                        w_state_nx = UART_ST_STOP;
`endif
                    end
                end
            end
`ifdef DBG_UART_PARITY_EN
            UART_ST_PAR: begin
                if (w_bit_end) begin
                    w_txd_nx   = 1'b1;
                    w_baud_nx  = BAUD_LOAD;
                    w_state_nx = UART_ST_STOP;
                end
            end
`endif
            UART_ST_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        // Chain straight into the next start bit, no idle gap.
                        w_pop      = 1'b1;
                        w_shreg_nx = w_head;
`ifdef DBG_UART_PARITY_EN
                        w_par_nx   = ^w_head;
`endif
                        w_txd_nx   = 1'b0;
                        w_baud_nx  = BAUD_LOAD;
                        w_state_nx = UART_ST_START;
                    end else begin
                        w_txd_nx   = 1'b1;
                        w_state_nx = UART_ST_IDLE;
                    end
                end
            end
            default: begin
                w_txd_nx   = 1'b1;
                w_state_nx = UART_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= UART_ST_IDLE;
            r_baud   <= '0;
            r_bitcnt <= 3'd0;
            r_txd    <= 1'b1;
        end else begin
            r_state  <= w_state_nx;
            r_baud   <= w_baud_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_txd    <= w_txd_nx;
        end
    end

    // Byte being shifted; only meaningful while a frame is in flight.
    always_ff @(posedge clk) begin
        r_shreg <= w_shreg_nx;
`ifdef DBG_UART_PARITY_EN
        r_par   <= w_par_nx;
`endif
    end

endmodule

// File: tb/tb_dbg_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_dbg_uart_tx
// Self-checking bench for dbg_uart_tx. Main instance: CLK_DIV=4, FIFO_DEPTH=4.
// Second instance: CLK_DIV=3, FIFO_DEPTH=16, decoded by a receiver model.
// Expected frames follow DBG_UART_PARITY_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_dbg_uart_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int DIV2  = 3;
`ifdef DBG_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_vld = 1'b0;
    logic [7:0] in_dat = 8'h00;
    logic       in_rdy, txd, busy;
    logic       in_vld2 = 1'b0;
    logic [7:0] in_dat2 = 8'h00;
    logic       in_rdy2, txd2, busy2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dbg_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_dat(in_dat),
        .in_rdy(in_rdy), .txd(txd), .busy(busy)
    );

    dbg_uart_tx #(.CLK_DIV(DIV2), .FIFO_DEPTH(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_vld(in_vld2), .in_dat(in_dat2),
        .in_rdy(in_rdy2), .txd(txd2), .busy(busy2)
    );

    // Vector: byte, hand-computed 8N1 frame {stop, data, start} (bit 0 first
    // on the wire) and hand-computed even parity of the byte.
    typedef struct {
        logic [7:0] dat;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d);
`ifdef DBG_UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    function automatic logic [10:0] tbl_frame(input vec_t v);
`ifdef DBG_UART_PARITY_EN
        return {1'b1, v.par, v.frame[8:0]};
`else
        return {1'b0, v.frame};
`endif
    endfunction

    // Called #1 after the edge that starts the frame; checks every cycle of
    // every bit and returns #1 after the edge following the last stop cycle.
    task automatic check_frame(input logic [10:0] f, input string nm);
        logic bad;
        logic got;
        for (int b = 0; b < NB; b++) begin
            bad = 1'b0;
            got = f[b];
            for (int c = 0; c < DIV; c++) begin
                if (txd !== f[b]) begin
                    bad = 1'b1;
                    got = txd;
                end
                @(posedge clk);
                #1;
            end
            check($sformatf("%s bit%0d", nm, b), {31'd0, got}, {31'd0, f[b]});
        end
    endtask

    // Present a byte to an idle main DUT; returns #1 after the accepting edge.
    task automatic push_one(input logic [7:0] d);
        @(negedge clk);
        in_vld = 1'b1;
        in_dat = d;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_dat = ~d;
    endtask

    int         acc;
    int         low_at;
    logic       rdy_s;
    logic [7:0] fb[6];
    logic [7:0] rb[10];

    initial begin
        vecs[0] = '{8'hA5, 10'h34A, 1'b0};
        vecs[1] = '{8'h00, 10'h200, 1'b0};
        vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[3] = '{8'h07, 10'h20E, 1'b1};
        vecs[4] = '{8'h3C, 10'h278, 1'b0};
        vecs[5] = '{8'h01, 10'h202, 1'b1};
        vecs[6] = '{8'h80, 10'h300, 1'b1};
        vecs[7] = '{8'h5A, 10'h2B4, 1'b0};
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 10; i++) rb[i] = 8'($urandom);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset txd", txd, 1);
        check("reset busy", busy, 0);
        check("reset in_rdy", in_rdy, 1);
        check("reset txd2", txd2, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single frames from the table
        for (int i = 0; i < 8; i++) begin
            push_one(vecs[i].dat);
            check($sformatf("vec%0d txd at E0", i), txd, 1);
            check($sformatf("vec%0d busy at E0", i), busy, 1);
            @(posedge clk);
            #1;
            check_frame(tbl_frame(vecs[i]), $sformatf("vec%0d", i));
            check($sformatf("vec%0d busy after", i), busy, 0);
            check($sformatf("vec%0d txd idle", i), txd, 1);
        end

        // Back-to-back: 0x00 then 0xFF on consecutive edges
        @(negedge clk);
        in_vld = 1'b1;
        in_dat = 8'h00;
        @(posedge clk);
        #1;
        in_dat = 8'hFF;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        check_frame(mk_frame(8'h00), "b2b first");
        check_frame(mk_frame(8'hFF), "b2b second");
        check("b2b busy after", busy, 0);

        // Full buffer: hold in_vld over 6 bytes
        low_at = -1;
        @(negedge clk);
        in_vld = 1'b1;
        in_dat = fb[0];
        @(posedge clk);
        acc = 1;
        fork
            begin
                int guard;
                guard = 0;
                while (acc < 6 && guard < 400) begin
                    @(negedge clk);
                    guard++;
                    if (!in_rdy && low_at < 0) low_at = acc;
                    in_dat = fb[acc];
                    rdy_s  = in_rdy;
                    @(posedge clk);
                    if (rdy_s) acc++;
                end
                #1;
                in_vld = 1'b0;
            end
            begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 6; i++) check_frame(mk_frame(fb[i]), $sformatf("full byte%0d", i));
            end
        join
        check("full in_rdy low after accepts", low_at, 5);
        check("full accepted count", acc, 6);
        check("full busy after", busy, 0);
        check("full in_rdy after", in_rdy, 1);

        // Reset during data bit 3 of 0xA5 (bit 3 is 0), second byte queued
        push_one(8'hA5);
        push_one(8'h5A);
        repeat (17) @(posedge clk);
        #1;
        check("rst pre txd bit3", txd, 0);
        rst = 1'b1;
        #1;
        check("rst txd", txd, 1);
        check("rst busy", busy, 0);
        check("rst in_rdy", in_rdy, 1);
        @(negedge clk);
        rst = 1'b0;
        begin
            logic bad;
            bad = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(posedge clk);
                #1;
                if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
            end
            check("rst no retransmit", {31'd0, bad}, 0);
        end

        // Random traffic on the CLK_DIV=3 instance, decoded by a receiver model
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    in_vld2 = 1'b1;
                    in_dat2 = rb[k];
                    @(posedge clk);
                    #1;
                    in_vld2 = 1'b0;
                    repeat ($urandom_range(0, 40)) @(posedge clk);
                end
            end
            begin
                logic [7:0] d;
                int         t;
                for (int k = 0; k < 10; k++) begin
                    t = 0;
                    @(posedge clk);
                    #1;
                    while (txd2 !== 1'b0 && t < 400) begin
                        @(posedge clk);
                        #1;
                        t++;
                    end
                    if (t >= 400) begin
                        check($sformatf("rx%0d start timeout", k), 1, 0);
                        break;
                    end
                    @(posedge clk);
                    #1;
                    check($sformatf("rx%0d start mid", k), txd2, 0);
                    for (int b = 0; b < 8; b++) begin
                        repeat (DIV2) @(posedge clk);
                        #1;
                        d[b] = txd2;
                    end
                    check($sformatf("rx%0d byte", k), d, rb[k]);
`ifdef DBG_UART_PARITY_EN
                    repeat (DIV2) @(posedge clk);
                    #1;
                    check($sformatf("rx%0d parity", k), txd2, ^rb[k]);
`endif
                    repeat (DIV2) @(posedge clk);
                    #1;
                    check($sformatf("rx%0d stop", k), txd2, 1);
                end
            end
        join
        repeat (DIV2 * 2) @(posedge clk);
        #1;
        check("rx busy2 after", busy2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
